// File: rtl/vec_mem_sequencer_pkg.sv
// Shared types and constants for the vector memory sequencer.
//   state_e   : sequencer FSM state encoding
//   LANES     : default number of 32-bit lanes per vector access
//   WORD_W    : memory word / lane width
//   VEC_W     : full vector width (LANES * WORD_W)
//   lane_addr : byte address of a lane, wrapping modulo 2^32
package vmem_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned VEC_W  = 128;

   typedef enum logic [2:0] {
      StIdle,
      StStore,
      StLoad,
      StDrain,
      StDone
   } state_e;

   // 32-bit add drops the carry, so addresses wrap past 32'hFFFFFFFF.
   function automatic logic [WORD_W-1:0] lane_addr(input logic [WORD_W-1:0] base,
                                                   input int unsigned       lane,
                                                   input int unsigned       stride);
      return base + (lane * stride);
   endfunction

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Single-port memory data bus between the sequencer and a memory.
//   mem_addr  : byte address presented to memory
//   mem_wdata : write data
//   mem_we    : write enable
//   mem_rdata : read data, valid one cycle after mem_addr
// master = sequencer side, slave = memory side.
interface vec_mem_sequencer_if;
   import vmem_pkg::*;

   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_we;
   logic [WORD_W-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      output mem_rdata
   );

endinterface

// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: splits one vector access into LANES single-word memory
// accesses on a shared memory port and reassembles load results.
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset
//   start      : request pulse, accepted only when idle
//   is_store   : 1 = store, 0 = load (sampled with start)
//   base_addr  : byte address of lane 0 (sampled with start)
//   store_data : vector to store, lane k in bits 32k+31:32k (sampled with start)
//   busy       : stall request while the access is in flight
//   done       : one-cycle completion pulse
//   load_data  : assembled load vector, held until the next accepted load
//   mem        : memory data port (master side)
module vec_mem_sequencer #(
   parameter int unsigned LANES       = vmem_pkg::LANES,
   parameter int unsigned ADDR_STRIDE = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       is_store,
   input  logic [31:0]                base_addr,
   input  logic [vmem_pkg::VEC_W-1:0] store_data,
   output logic                       busy,
   output logic                       done,
   output logic [vmem_pkg::VEC_W-1:0] load_data,
   vec_mem_sequencer_if.master        mem
);
   import vmem_pkg::*;

   localparam int unsigned    LaneW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);

   state_e           state_q;
   logic [LaneW-1:0] lane_q;
   logic [31:0]      base_q;
   logic [VEC_W-1:0] data_q;
   logic [VEC_W-1:0] load_q;
   logic             busy_q;
   logic             done_q;

   logic [LaneW-1:0] lane_nxt;
   logic [LaneW-1:0] lane_prev;

   assign lane_nxt  = lane_q + LaneW'(1);
   assign lane_prev = lane_q - LaneW'(1);

   // Bus outputs are registered: the beat for lane k is set up on the edge before it
   // appears, so lane 0 is driven straight from the request inputs on the accepting edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         lane_q        <= '0;
         base_q        <= '0;
         data_q        <= '0;
         load_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         mem.mem_we    <= 1'b0;
      end else begin
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         mem.mem_we    <= 1'b0;
         done_q        <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  base_q       <= base_addr;
                  data_q       <= store_data;
                  lane_q       <= '0;
                  busy_q       <= 1'b1;
                  mem.mem_addr <= base_addr;
                  if (is_store) begin
                     state_q       <= StStore;
                     mem.mem_we    <= 1'b1;
                     mem.mem_wdata <= store_data[WORD_W-1:0];
                  end else begin
                     state_q <= StLoad;
                  end
               end
            end
            StStore: begin
               if (lane_q == LastLane) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  lane_q        <= lane_nxt;
                  mem.mem_addr  <= lane_addr(base_q, 32'(lane_nxt), ADDR_STRIDE);
                  mem.mem_wdata <= data_q[32'(lane_nxt) * WORD_W +: WORD_W];
                  mem.mem_we    <= 1'b1;
               end
            end
            StLoad: begin
               // Read data trails its address by one cycle, so this edge retires lane k-1.
               if (lane_q != '0) begin
                  load_q[32'(lane_prev) * WORD_W +: WORD_W] <= mem.mem_rdata;
               end
               if (lane_q == LastLane) begin
                  state_q <= StDrain;
               end else begin
                  lane_q       <= lane_nxt;
                  mem.mem_addr <= lane_addr(base_q, 32'(lane_nxt), ADDR_STRIDE);
               end
            end
            StDrain: begin
               load_q[(LANES - 1) * WORD_W +: WORD_W] <= mem.mem_rdata;
               state_q <= StDone;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign load_data = load_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer with a behavioural memory and vector model.
// Cycle c of an operation is the clock period ending at edge c, edge 0 being the
// accepting edge; DUT outputs are sampled at the falling edge inside each period.
module tb_vec_mem_sequencer;
   import vmem_pkg::*;

   localparam int unsigned NL   = 4;
   localparam int unsigned STR  = 4;
   localparam int          MAXC = 20;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         is_store = 1'b0;
   logic [31:0]  base_addr = '0;
   logic [127:0] store_data = '0;
   logic         busy;
   logic         done;
   logic [127:0] load_data;

   vec_mem_sequencer_if mem_bus ();

   vec_mem_sequencer #(
      .LANES      (NL),
      .ADDR_STRIDE(STR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_store  (is_store),
      .base_addr (base_addr),
      .store_data(store_data),
      .busy      (busy),
      .done      (done),
      .load_data (load_data),
      .mem       (mem_bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Memory: logs every write it accepts, returns addr ^ key one cycle after the address.
   logic [31:0] key = 32'h5A5A5A5A;
   logic [63:0] wlog[$];
   always @(posedge clk) begin
      if (mem_bus.mem_we === 1'b1) wlog.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
      mem_bus.mem_rdata <= mem_bus.mem_addr ^ key;
   end

   // Expected content of load_data: last completed load, cleared by reset.
   logic [127:0] ld_model = '0;

   logic         tr_we   [0:MAXC];
   logic         tr_busy [0:MAXC];
   logic         tr_done [0:MAXC];
   logic [31:0]  tr_addr [0:MAXC];
   logic [31:0]  tr_wdata[0:MAXC];
   logic [127:0] tr_ld   [0:MAXC];

   task automatic sample(input int c);
      tr_we[c]    = mem_bus.mem_we;
      tr_busy[c]  = busy;
      tr_done[c]  = done;
      tr_addr[c]  = mem_bus.mem_addr;
      tr_wdata[c] = mem_bus.mem_wdata;
      tr_ld[c]    = load_data;
   endtask

   // Issues one request from idle and records cycles 0..n; request inputs are
   // scrambled after acceptance so the operation must use its captured copy.
   task automatic run_op(input bit st, input logic [31:0] b, input logic [127:0] d, input int n);
      wlog.delete();
      is_store   = st;
      base_addr  = b;
      store_data = d;
      start      = 1'b1;
      sample(0);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         start      = 1'b0;
         is_store   = 1'($urandom);
         base_addr  = $urandom;
         store_data = {$urandom, $urandom, $urandom, $urandom};
         sample(c);
      end
   endtask

   function automatic logic [127:0] exp_load(input logic [31:0] b, input logic [31:0] k);
      logic [127:0] v;
      for (int i = 0; i < int'(NL); i++) v[32*i +: 32] = (b + 32'(i) * STR) ^ k;
      return v;
   endfunction

   task automatic test_reset();
      reset    = 1'b0;
      start    = 1'b1;
      is_store = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (mem_bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_bus.mem_we); end
      checks++; if (mem_bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_bus.mem_addr); end
      checks++; if (mem_bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_bus.mem_wdata); end
      checks++; if (load_data !== 128'h0) begin errors++; $display("FAIL reset_load_data: got %h want 0", load_data); end
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_store(input string nm, input logic [31:0] b, input logic [127:0] d);
      bit          e_we;
      bit          e_busy;
      bit          e_done;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      run_op(1'b1, b, d, NL + 3);
      checks++;
      if (wlog.size() != NL) begin
         errors++; $display("FAIL %s write_count: got %0d want %0d", nm, wlog.size(), NL);
      end
      for (int k = 0; k < int'(NL) && k < wlog.size(); k++) begin
         checks++;
         if (wlog[k] !== {b + 32'(k) * STR, d[32*k +: 32]}) begin
            errors++; $display("FAIL %s write%0d: got %h want %h", nm, k, wlog[k], {b + 32'(k) * STR, d[32*k +: 32]});
         end
      end
      for (int c = 1; c <= int'(NL) + 3; c++) begin
         e_we   = (c <= int'(NL));
         e_busy = (c <= int'(NL));
         e_done = (c == int'(NL) + 1);
         e_addr = e_we ? b + 32'(c - 1) * STR : 32'h0;
         e_wd   = e_we ? d[32*(c-1) +: 32] : 32'h0;
         checks++;
         if ({tr_we[c], tr_busy[c], tr_done[c]} !== {e_we, e_busy, e_done}) begin
            errors++; $display("FAIL %s ctl_c%0d: got we/busy/done %b%b%b want %b%b%b", nm, c,
                               tr_we[c], tr_busy[c], tr_done[c], e_we, e_busy, e_done);
         end
         checks++;
         if ({tr_addr[c], tr_wdata[c]} !== {e_addr, e_wd}) begin
            errors++; $display("FAIL %s bus_c%0d: got %h/%h want %h/%h", nm, c, tr_addr[c], tr_wdata[c], e_addr, e_wd);
         end
         checks++;
         if (tr_ld[c] !== ld_model) begin
            errors++; $display("FAIL %s load_data_c%0d: got %h want %h", nm, c, tr_ld[c], ld_model);
         end
      end
   endtask

   task automatic test_load(input string nm, input logic [31:0] b, input logic [31:0] k);
      logic [127:0] ev;
      logic [31:0]  e_addr;
      bit           e_busy;
      bit           e_done;
      key = k;
      ev  = exp_load(b, k);
      run_op(1'b0, b, {$urandom, $urandom, $urandom, $urandom}, NL + 3);
      checks++;
      if (wlog.size() != 0) begin errors++; $display("FAIL %s writes: got %0d want 0", nm, wlog.size()); end
      for (int c = 1; c <= int'(NL) + 3; c++) begin
         e_addr = (c <= int'(NL)) ? b + 32'(c - 1) * STR : 32'h0;
         e_busy = (c <= int'(NL) + 1);
         e_done = (c == int'(NL) + 2);
         checks++;
         if ({tr_we[c], tr_busy[c], tr_done[c]} !== {1'b0, e_busy, e_done}) begin
            errors++; $display("FAIL %s ctl_c%0d: got we/busy/done %b%b%b want 0%b%b", nm, c,
                               tr_we[c], tr_busy[c], tr_done[c], e_busy, e_done);
         end
         checks++;
         if (tr_addr[c] !== e_addr) begin
            errors++; $display("FAIL %s addr_c%0d: got %h want %h", nm, c, tr_addr[c], e_addr);
         end
         if (c <= 2) begin
            checks++;
            if (tr_ld[c] !== ld_model) begin
               errors++; $display("FAIL %s held_c%0d: got %h want %h", nm, c, tr_ld[c], ld_model);
            end
         end
         if (c >= int'(NL) + 2) begin
            checks++;
            if (tr_ld[c] !== ev) begin
               errors++; $display("FAIL %s result_c%0d: got %h want %h", nm, c, tr_ld[c], ev);
            end
         end
      end
      ld_model = ev;
   endtask

   task automatic test_wrap();
      test_store("wrap", 32'hFFFFFFF8, {$urandom, $urandom, $urandom, $urandom});
      checks++;
      if (wlog.size() < 3 || wlog[2][63:32] !== 32'h0000_0000) begin
         errors++; $display("FAIL wrap_lane2_addr: got %h want 00000000", (wlog.size() < 3) ? 32'hx : wlog[2][63:32]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(1, 0) == 1)
            test_store("rnd_store", $urandom, {$urandom, $urandom, $urandom, $urandom});
         else
            test_load("rnd_load", $urandom, $urandom);
      end
   endtask

   task automatic test_busy_ignore();
      logic [127:0] d;
      int           n_done;
      bit           late_busy;
      d      = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      n_done = 0;
      late_busy = 1'b0;
      wlog.delete();
      is_store = 1'b1; base_addr = 32'h300; store_data = d; start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start = (c == 2);  // second request lands while the store is in flight
         store_data = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
         base_addr  = 32'h900;
         if (done === 1'b1) n_done++;
         if (c > int'(NL) && busy !== 1'b0) late_busy = 1'b1;
      end
      checks++;
      if (wlog.size() != NL) begin errors++; $display("FAIL busy_ignore_writes: got %0d want %0d", wlog.size(), NL); end
      for (int k = 0; k < int'(NL) && k < wlog.size(); k++) begin
         checks++;
         if (wlog[k] !== {32'h300 + 32'(k) * STR, d[32*k +: 32]}) begin
            errors++; $display("FAIL busy_ignore_write%0d: got %h", k, wlog[k]);
         end
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL busy_ignore_done_count: got %0d want 1", n_done); end
      checks++; if (late_busy) begin errors++; $display("FAIL busy_ignore_extra_op: got busy after store want idle"); end
      test_store("after_ignore", 32'h500, {$urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic test_reset_mid();
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      wlog.delete();
      is_store = 1'b1; base_addr = 32'h400; store_data = d; start = 1'b1;
      @(negedge clk);  // lane 0 on the bus; reset takes effect on the edge that writes it
      reset = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         if (c == 4) begin reset = 1'b1; start = 1'b0; end
         checks++;
         if ({mem_bus.mem_we, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_ctl_c%0d: got we/busy/done %b%b%b want 000", c, mem_bus.mem_we, busy, done);
         end
         checks++;
         if (load_data !== 128'h0) begin errors++; $display("FAIL reset_mid_load_c%0d: got %h want 0", c, load_data); end
      end
      checks++;
      if (wlog.size() != 1 || wlog[0] !== {32'h400, d[31:0]}) begin
         errors++; $display("FAIL reset_mid_writes: got %0d writes want only lane 0", wlog.size());
      end
      ld_model = '0;
   endtask

   task automatic test_back_to_back();
      int           dl[$];
      logic [31:0]  b1;
      logic [31:0]  b2;
      logic [127:0] ld_at[$];
      b1 = $urandom; b2 = $urandom;
      key = $urandom;
      is_store = 1'b0; base_addr = b1; start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 3) base_addr = b2;
         if (c == 8) start = 1'b0;
         if (done === 1'b1) begin dl.push_back(c); ld_at.push_back(load_data); end
      end
      checks++;
      if (dl.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dl.size()); end
      else begin
         checks++; if (dl[0] != 6) begin errors++; $display("FAIL b2b_first_done: got c%0d want c6", dl[0]); end
         checks++; if (dl[1] - dl[0] != 7) begin errors++; $display("FAIL b2b_spacing: got %0d want 7", dl[1] - dl[0]); end
         checks++; if (ld_at[0] !== exp_load(b1, key)) begin errors++; $display("FAIL b2b_data1: got %h want %h", ld_at[0], exp_load(b1, key)); end
         checks++; if (ld_at[1] !== exp_load(b2, key)) begin errors++; $display("FAIL b2b_data2: got %h want %h", ld_at[1], exp_load(b2, key)); end
      end
      ld_model = exp_load(b2, key);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_store("store_dir", 32'h100, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      test_load("load_dir", 32'h200, 32'h5A5A5A5A);
      test_store("store_keeps_load", 32'h180, {$urandom, $urandom, $urandom, $urandom});
      test_wrap();
      test_random();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_load("final_load", $urandom, $urandom);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
